// File: rtl/hc_pkg.sv
// Shared helpers for the Han-Carlson prefix blocks: level count, prefix cell
// functions and a generic pipeline slot type.
package hc_pkg;

  localparam int PAYLOAD_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [PAYLOAD_W-1:0] payload;
  } pipe_slot_t;

  function automatic int levels(input int width);
    return $clog2(width);
  endfunction

  function automatic logic gray_g(input logic g_hi, input logic p_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

  function automatic logic black_p(input logic p_hi, input logic p_lo);
    return p_hi & p_lo;
  endfunction

  function automatic logic stage_advance(input logic valid, input logic next_advance);
    return ~valid | next_advance;
  endfunction

endpackage

// File: rtl/hc_prefix_net.sv
// Combinational Han-Carlson group-generate network: a Kogge-Stone tree on the
// odd bit positions followed by one gray-cell row for the even positions.
module hc_prefix_net
  import hc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] gi
);

  localparam int LEVELS = levels(WIDTH);

  logic [WIDTH-1:0] gl_s [0:LEVELS];
  logic [WIDTH-1:0] pl_s [0:LEVELS];

  // Odd-position prefix tree; even positions pass through until the final row.
  always_comb begin
    gl_s[0] = g;
    pl_s[0] = p;
    for (int k = 1; k <= LEVELS; k++) begin
      gl_s[k] = gl_s[k-1];
      pl_s[k] = pl_s[k-1];
      for (int i = 1; i < WIDTH; i += 2) begin
        if (i - (1 << (k - 1)) >= 0) begin
          gl_s[k][i] = gray_g(gl_s[k-1][i], pl_s[k-1][i], gl_s[k-1][i - (1 << (k - 1))]);
          pl_s[k][i] = black_p(pl_s[k-1][i], pl_s[k-1][i - (1 << (k - 1))]);
        end else begin
          gl_s[k][i] = gl_s[k-1][i];
          pl_s[k][i] = pl_s[k-1][i];
        end
      end
    end
  end

  // Final gray row: each even bit picks up the completed prefix of its odd neighbour.
  always_comb begin
    gi = gl_s[LEVELS];
    for (int i = 2; i < WIDTH; i += 2) begin
      gi[i] = gray_g(gl_s[LEVELS][i], pl_s[LEVELS][i], gl_s[LEVELS][i-1]);
    end
  end

endmodule

// File: rtl/hc_pipelined_subtractor.sv
// Three-stage pipelined Han-Carlson subtractor: diff = a - b - bin with borrow,
// signed-overflow and zero flags behind a valid/ready handshake.
module hc_pipelined_subtractor
  import hc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int VALENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  if (VALENCY != 2 || WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_param_check
    $error("hc_pipelined_subtractor: unsupported WIDTH or VALENCY");
  end

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_nb_r;
  logic             s1_cin_r;
  logic [WIDTH-1:0] s1_g_s;
  logic [WIDTH-1:0] s1_p_s;
  logic [WIDTH-1:0] gi_s;

  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_gi_r;
  logic [WIDTH-1:0] s2_p_r;
  logic             s2_cin_r;
  logic             s2_amsb_r;
  logic             s2_bmsb_r;
  logic [WIDTH-1:0] diff_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic             zero_r;

  logic             adv1_s;
  logic             adv2_s;
  logic             adv3_s;

  // Backpressure ripples from out_ready toward the input; in_valid never feeds in_ready.
  always_comb begin
    adv3_s   = stage_advance(out_valid_r, out_ready);
    adv2_s   = stage_advance(s2_valid_r, adv3_s);
    adv1_s   = stage_advance(s1_valid_r, adv2_s);
    in_ready = adv1_s;
  end

  // Subtraction as a + ~b + ~bin; the carry-in is folded into bit 0's generate.
  always_comb begin
    s1_p_s    = s1_a_r ^ s1_nb_r;
    s1_g_s    = s1_a_r & s1_nb_r;
    s1_g_s[0] = gray_g(s1_a_r[0] & s1_nb_r[0], s1_p_s[0], s1_cin_r);
    diff_s    = s2_p_r ^ {s2_gi_r[WIDTH-2:0], s2_cin_r};
  end

  hc_prefix_net #(.WIDTH(WIDTH)) u_prefix_net (
    .g  (s1_g_s),
    .p  (s1_p_s),
    .gi (gi_s)
  );

  // Stage 1: operand register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_nb_r    <= '0;
      s1_cin_r   <= 1'b0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r   <= a;
        s1_nb_r  <= ~b;
        s1_cin_r <= ~bin;
      end
    end
  end

  // Stage 2: prefix register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_gi_r    <= '0;
      s2_p_r     <= '0;
      s2_cin_r   <= 1'b0;
      s2_amsb_r  <= 1'b0;
      s2_bmsb_r  <= 1'b0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_gi_r   <= gi_s;
        s2_p_r    <= s1_p_s;
        s2_cin_r  <= s1_cin_r;
        s2_amsb_r <= s1_a_r[WIDTH-1];
        s2_bmsb_r <= ~s1_nb_r[WIDTH-1];
      end
    end
  end

  // Stage 3: output register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      diff_r      <= '0;
      bout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else if (adv3_s) begin
      out_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        diff_r <= diff_s;
        bout_r <= ~s2_gi_r[WIDTH-1];
        ovf_r  <= (s2_amsb_r != s2_bmsb_r) && (diff_s[WIDTH-1] != s2_amsb_r);
        zero_r <= ~|diff_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_hc_pipelined_subtractor.sv
// Scoreboard bench for hc_pipelined_subtractor at WIDTH=16 and WIDTH=4.
module tb_hc_pipelined_subtractor;

  logic        clk;
  logic        rst;

  logic        in_valid_16, in_ready_16, bin_16, out_valid_16, out_ready_16;
  logic        bout_16, ovf_16, zero_16;
  logic [15:0] a_16, b_16, diff_16;

  logic        in_valid_4, in_ready_4, bin_4, out_valid_4, out_ready_4;
  logic        bout_4, ovf_4, zero_4;
  logic [3:0]  a_4, b_4, diff_4;

  int checks = 0;
  int errors = 0;
  int pops_16 = 0;
  int pops_4 = 0;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } res16_t;

  typedef struct packed {
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } res4_t;

  res16_t q16[$];
  res4_t  q4[$];

  hc_pipelined_subtractor #(.WIDTH(16), .VALENCY(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .a(a_16), .b(b_16), .bin(bin_16), .out_valid(out_valid_16), .out_ready(out_ready_16),
    .diff(diff_16), .bout(bout_16), .ovf(ovf_16), .zero(zero_16)
  );

  hc_pipelined_subtractor #(.WIDTH(4), .VALENCY(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .a(a_4), .b(b_4), .bin(bin_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
    .diff(diff_4), .bout(bout_4), .ovf(ovf_4), .zero(zero_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: widened unsigned subtraction; the top bit of the wide result is the borrow.
  function automatic res16_t model16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    logic [16:0] full;
    res16_t r;
    full   = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    r.diff = full[15:0];
    r.bout = full[16];
    r.ovf  = (a[15] != b[15]) && (r.diff[15] != a[15]);
    r.zero = (r.diff == 16'd0);
    return r;
  endfunction

  function automatic res4_t model4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    logic [4:0] full;
    res4_t r;
    full   = {1'b0, a} - {1'b0, b} - {4'd0, bi};
    r.diff = full[3:0];
    r.bout = full[4];
    r.ovf  = (a[3] != b[3]) && (r.diff[3] != a[3]);
    r.zero = (r.diff == 4'd0);
    return r;
  endfunction

  // Handshakes are sampled mid-cycle; both fire on the following rising edge.
  always @(negedge clk) begin
    res16_t e16;
    res4_t  e4;
    if (!rst) begin
      if (out_valid_16 && out_ready_16) begin
        checks++;
        pops_16++;
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL sb16_unexpected got diff=%h with empty scoreboard", diff_16);
        end else begin
          e16 = q16.pop_front();
          if ({diff_16, bout_16, ovf_16, zero_16} !== e16) begin
            errors++;
            $display("FAIL sb16 got diff=%h bout=%b ovf=%b zero=%b want diff=%h bout=%b ovf=%b zero=%b",
                     diff_16, bout_16, ovf_16, zero_16, e16.diff, e16.bout, e16.ovf, e16.zero);
          end
        end
      end
      if (in_valid_16 && in_ready_16) q16.push_back(model16(a_16, b_16, bin_16));
      if (out_valid_4 && out_ready_4) begin
        checks++;
        pops_4++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL sb4_unexpected got diff=%h with empty scoreboard", diff_4);
        end else begin
          e4 = q4.pop_front();
          if ({diff_4, bout_4, ovf_4, zero_4} !== e4) begin
            errors++;
            $display("FAIL sb4 got diff=%h bout=%b ovf=%b zero=%b want diff=%h bout=%b ovf=%b zero=%b",
                     diff_4, bout_4, ovf_4, zero_4, e4.diff, e4.bout, e4.ovf, e4.zero);
          end
        end
      end
      if (in_valid_4 && in_ready_4) q4.push_back(model4(a_4, b_4, bin_4));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid_16 = 1'b0; a_16 = 16'd0; b_16 = 16'd0; bin_16 = 1'b0; out_ready_16 = 1'b1;
    in_valid_4 = 1'b0; a_4 = 4'd0; b_4 = 4'd0; bin_4 = 1'b0; out_ready_4 = 1'b1;
    #1 rst = 1'b1;
    repeat (2) next_cycle();
    checks++;
    if ({out_valid_16, diff_16, bout_16, ovf_16, zero_16} !== 20'd0) begin
      errors++;
      $display("FAIL reset16 got valid=%b diff=%h flags=%b%b%b want all zero",
               out_valid_16, diff_16, bout_16, ovf_16, zero_16);
    end
    checks++;
    if ({out_valid_4, diff_4, bout_4, ovf_4, zero_4} !== 8'd0) begin
      errors++;
      $display("FAIL reset4 got valid=%b diff=%h flags=%b%b%b want all zero",
               out_valid_4, diff_4, bout_4, ovf_4, zero_4);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_16 !== 1'b1 || in_ready_4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b/%b want 1/1", in_ready_16, in_ready_4);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [6] = '{16'h0005, 16'h0000, 16'h1234, 16'h8000, 16'h7FFF, 16'h1234};
    logic [15:0] vb [6] = '{16'h0003, 16'h0001, 16'h1233, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic        vi [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] ed [6] = '{16'h0002, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h1234};
    logic [2:0]  ef [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110, 3'b100};
    for (int v = 0; v < 6; v++) begin
      next_cycle();
      in_valid_16 = 1'b1; a_16 = va[v]; b_16 = vb[v]; bin_16 = vi[v];
      next_cycle();
      in_valid_16 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        checks++;
        if (out_valid_16 !== (c == 3)) begin
          errors++;
          $display("FAIL latency vec%0d cycle%0d got out_valid=%b want %b", v, c, out_valid_16, c == 3);
        end
        if (c < 3) next_cycle();
      end
      checks++;
      if ({diff_16, bout_16, ovf_16, zero_16} !== {ed[v], ef[v]}) begin
        errors++;
        $display("FAIL directed vec%0d got diff=%h bout/ovf/zero=%b%b%b want diff=%h flags=%b",
                 v, diff_16, bout_16, ovf_16, zero_16, ed[v], ef[v]);
      end
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_back_to_back();
    int seen = 0, run = 0, best = 0, drops = 0;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      if (c < 20) begin
        in_valid_16 = 1'b1;
        a_16 = 16'($urandom); b_16 = 16'($urandom); bin_16 = 1'($urandom);
        if (in_ready_16 !== 1'b1) drops++;
      end else begin
        in_valid_16 = 1'b0;
      end
      if (out_valid_16 === 1'b1) begin
        seen++; run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    checks++;
    if (seen != 20 || best != 20 || drops != 0) begin
      errors++;
      $display("FAIL back_to_back got results=%0d run=%0d ready_drops=%0d want 20/20/0", seen, best, drops);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0, start = pops_16, unstable = 0;
    logic held_ok = 1'b0;
    logic [18:0] held = 19'd0;
    next_cycle();
    out_ready_16 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid_16 = 1'b1;
      a_16 = 16'($urandom); b_16 = 16'($urandom); bin_16 = 1'($urandom);
      #1;
      if (in_ready_16 === 1'b1) acc++;
      if (out_valid_16 === 1'b1) begin
        if (!held_ok) begin
          held = {diff_16, bout_16, ovf_16, zero_16};
          held_ok = 1'b1;
        end else if ({diff_16, bout_16, ovf_16, zero_16} !== held) begin
          unstable++;
        end
      end
      next_cycle();
    end
    in_valid_16 = 1'b0;
    checks++;
    if (acc != 3 || in_ready_16 !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept got accepted=%0d in_ready=%b want 3/0", acc, in_ready_16);
    end
    checks++;
    if (!held_ok || unstable != 0 || out_valid_16 !== 1'b1 ||
        {diff_16, bout_16, ovf_16, zero_16} !== held) begin
      errors++;
      $display("FAIL stall_hold got seen=%b changes=%0d valid=%b want held outputs",
               held_ok, unstable, out_valid_16);
    end
    out_ready_16 = 1'b1;
    for (int c = 0; c < 10 && (q16.size() != 0 || out_valid_16 === 1'b1); c++) next_cycle();
    next_cycle();
    checks++;
    if (pops_16 - start != 3 || q16.size() != 0) begin
      errors++;
      $display("FAIL drain got drained=%0d pending=%0d want 3/0", pops_16 - start, q16.size());
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      in_valid_16 = 1'b1;
      a_16 = 16'($urandom); b_16 = 16'($urandom); bin_16 = 1'($urandom);
    end
    next_cycle();
    in_valid_16 = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (out_valid_16 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid got %b want 1", out_valid_16);
    end
    rst = 1'b1;
    #1;
    q16.delete();
    checks++;
    if ({out_valid_16, diff_16, bout_16, ovf_16, zero_16} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset got valid=%b diff=%h flags=%b%b%b want all zero",
               out_valid_16, diff_16, bout_16, ovf_16, zero_16);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_16 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got %b want 1", in_ready_16);
    end
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      if (out_valid_16 !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL stale_beat got %0d valid cycles want 0", stale);
    end
  endtask

  task automatic test_exhaustive4();
    int start = pops_4, stalls = 0;
    for (int i = 0; i < 512; i++) begin
      next_cycle();
      in_valid_4 = 1'b1;
      a_4 = 4'(i >> 5); b_4 = 4'(i >> 1); bin_4 = i[0];
      if (in_ready_4 !== 1'b1) stalls++;
    end
    next_cycle();
    in_valid_4 = 1'b0;
    repeat (6) next_cycle();
    checks++;
    if (pops_4 - start != 512 || q4.size() != 0 || stalls != 0) begin
      errors++;
      $display("FAIL exhaustive4 got results=%0d pending=%0d stalls=%0d want 512/0/0",
               pops_4 - start, q4.size(), stalls);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_exhaustive4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
